// File: rtl/spin_sequencer.sv
// Slot-machine game controller: bet check, reel stop sequencing, payout and credit.
// Optional `SPIN_SEQ_JACKPOT_EN: a 777 result pays 255.
module spin_sequencer #(
    parameter int          REEL_DELAY    = 4,
    parameter logic [7:0]  START_CREDITS = 8'd100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spin_req,
    input  logic [3:0]  bet,
    input  logic [11:0] rand_cnt,
    output logic [11:0] reels,
    output logic [7:0]  credits,
    output logic [7:0]  payout,
    output logic        busy,
    output logic        win,
    output logic        done,
    output logic        reject
);

    localparam int TW = (REEL_DELAY > 1) ? $clog2(REEL_DELAY) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(REEL_DELAY - 1);

    typedef enum logic [2:0] {
        IDLE, STOP0, STOP1, STOP2, EVAL, CREDIT
    } state_t;

    state_t        state_q, state_d;
    logic          req_q;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    bet_q, bet_d;
    logic [7:0]    credits_q, credits_d;
    logic [11:0]   reels_q, reels_d;
    logic [7:0]    payout_q, payout_d;
    logic          busy_q, win_q, win_d, done_q, done_d, reject_q, reject_d;

    logic       req_edge, tick, triple, pair, jackpot;
    logic [8:0] sum9;
    logic [7:0] pay_c;

    always_comb begin
        req_edge = spin_req & ~req_q;
        tick     = (timer_q == T_LAST);
        triple   = (reels_q[11:8] == reels_q[7:4]) && (reels_q[7:4] == reels_q[3:0]);
        pair     = (reels_q[11:8] == reels_q[7:4]) || (reels_q[7:4] == reels_q[3:0]);
`ifdef SPIN_SEQ_JACKPOT_EN
        jackpot  = (reels_q == 12'h777);
`else
        jackpot  = 1'b0;
`endif
        if (jackpot)     pay_c = 8'hFF;
        else if (triple) pay_c = {4'd0, bet_q} * 8'd10;
        else if (pair)   pay_c = {3'd0, bet_q, 1'b0};
        else             pay_c = 8'd0;
        sum9 = {1'b0, credits_q} + {1'b0, payout_q};

        state_d   = state_q;
        timer_d   = timer_q;
        bet_d     = bet_q;
        credits_d = credits_q;
        reels_d   = reels_q;
        payout_d  = payout_q;
        win_d     = 1'b0;
        done_d    = 1'b0;
        reject_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_edge) begin
                    if (bet != 4'd0 && {4'd0, bet} <= credits_q) begin
                        credits_d = credits_q - {4'd0, bet};
                        bet_d     = bet;
                        timer_d   = '0;
                        state_d   = STOP0;
                    end else begin
                        reject_d  = 1'b1;
                    end
                end
            end
            STOP0, STOP1, STOP2: begin
                timer_d = timer_q + TW'(1);
                if (tick) begin
                    timer_d = '0;
                    if (state_q == STOP0) begin
                        reels_d[11:8] = rand_cnt[11:8];
                        state_d       = STOP1;
                    end else if (state_q == STOP1) begin
                        reels_d[7:4]  = rand_cnt[7:4];
                        state_d       = STOP2;
                    end else begin
                        reels_d[3:0]  = rand_cnt[3:0];
                        state_d       = EVAL;
                    end
                end
            end
            EVAL: begin
                payout_d = pay_c;
                state_d  = CREDIT;
            end
            CREDIT: begin
                credits_d = sum9[8] ? 8'hFF : sum9[7:0];
                done_d    = 1'b1;
                win_d     = (payout_q != 8'd0);
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            timer_q   <= '0;
            bet_q     <= 4'd0;
            credits_q <= START_CREDITS;
            reels_q   <= 12'd0;
            payout_q  <= 8'd0;
            busy_q    <= 1'b0;
            win_q     <= 1'b0;
            done_q    <= 1'b0;
            reject_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= spin_req;
            timer_q   <= timer_d;
            bet_q     <= bet_d;
            credits_q <= credits_d;
            reels_q   <= reels_d;
            payout_q  <= payout_d;
            busy_q    <= (state_d != IDLE);
            win_q     <= win_d;
            done_q    <= done_d;
            reject_q  <= reject_d;
        end
    end

    assign reels   = reels_q;
    assign credits = credits_q;
    assign payout  = payout_q;
    assign busy    = busy_q;
    assign win     = win_q;
    assign done    = done_q;
    assign reject  = reject_q;

endmodule

// File: tb/tb_spin_sequencer.sv
// Bench for spin_sequencer: directed game scenarios plus randomized spins
// scored against a rule-level model of credits, reels and payouts.
module tb_spin_sequencer;

    localparam int         RD = 4;
    localparam logic [7:0] SC = 8'd20;

    logic        clk = 1'b0;
    logic        rst;
    logic        spin_req;
    logic [3:0]  bet;
    logic [11:0] rand_cnt;
    logic [11:0] reels;
    logic [7:0]  credits;
    logic [7:0]  payout;
    logic        busy, win, done, reject;

    spin_sequencer #(.REEL_DELAY(RD), .START_CREDITS(SC)) dut (
        .clk(clk), .rst(rst), .spin_req(spin_req), .bet(bet),
        .rand_cnt(rand_cnt), .reels(reels), .credits(credits),
        .payout(payout), .busy(busy), .win(win), .done(done),
        .reject(reject)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int credits_m;
    logic [11:0] reels_m;
    int payout_m;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pay_of(input int b, input logic [11:0] r);
        int r0 = int'(r[11:8]);
        int r1 = int'(r[7:4]);
        int r2 = int'(r[3:0]);
`ifdef SPIN_SEQ_JACKPOT_EN
        if (r == 12'h777) return 255;
`endif
        if (r0 == r1 && r1 == r2) return b * 10;
        if (r0 == r1 || r1 == r2) return b * 2;
        return 0;
    endfunction

    task automatic do_reset();
        rst = 1'b1; spin_req = 1'b0; bet = 4'd0; rand_cnt = 12'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        credits_m = int'(SC); reels_m = 12'd0; payout_m = 0;
        check("rst_credits", credits, credits_m);
        check("rst_reels", reels, 0);
        check("rst_payout", payout, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", {win, done, reject}, 0);
    endtask

    task automatic spin(input int b, input logic [11:0] r, input bit rnd,
                        input bit held, input bit chg);
        logic [11:0] rv [16];
        logic [11:0] e;
        int s;
        bet = 4'(b); rand_cnt = r; spin_req = 1'b1;
        @(negedge clk);
        if (b == 0 || b > credits_m) begin
            check("reject", reject, 1);
            check("rej_busy", busy, 0);
            check("rej_credits", credits, credits_m);
            spin_req = 1'b0;
            @(negedge clk);
            check("reject_clr", reject, 0);
            check("rej_idle", busy, 0);
            return;
        end
        credits_m -= b;
        check("debit", credits, credits_m);
        check("busy_a", busy, 1);
        check("no_reject", reject, 0);
        e = reels_m;
        for (int c = 1; c <= 15; c++) begin
            rv[c] = (rnd && (c % RD) != 0) ? 12'($urandom) : r;
            rand_cnt = rv[c];
            if (rnd) bet = 4'($urandom);
            if (chg && c == 1) bet = 4'd9;
            if (!held)
                spin_req = rnd ? ((c < 12) ? 1'($urandom) : 1'b0)
                               : (c == 6 || c == 7);
            @(negedge clk);
            if (c == RD)     e[11:8] = rv[c][11:8];
            if (c == 2 * RD) e[7:4]  = rv[c][7:4];
            if (c == 3 * RD) e[3:0]  = rv[c][3:0];
            check("reels", reels, e);
            check("reject_busy", reject, 0);
            if (c <= 13) begin
                check("busy", busy, 1);
                check("done_early", done, 0);
            end
            if (c == 12) check("payout_old", payout, payout_m);
            if (c == 13) begin
                payout_m = pay_of(b, e);
                check("payout", payout, payout_m);
            end
            if (c == 14) begin
                s = credits_m + payout_m;
                credits_m = (s > 255) ? 255 : s;
                check("done", done, 1);
                check("win", win, (payout_m != 0));
                check("busy_fall", busy, 0);
                check("credit", credits, credits_m);
            end
            if (c == 15) begin
                check("done_clr", done, 0);
                check("win_clr", win, 0);
                check("idle", busy, 0);
                check("credit_hold", credits, credits_m);
            end
        end
        reels_m = e;
        if (held) begin
            repeat (3) begin
                @(negedge clk);
                check("held_idle", busy, 0);
                check("held_noreject", reject, 0);
            end
            spin_req = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic mid_reset(input int b, input logic [11:0] r);
        bet = 4'(b); rand_cnt = r; spin_req = 1'b1;
        @(negedge clk);
        credits_m -= b;
        check("mr_debit", credits, credits_m);
        spin_req = 1'b0;
        repeat (5) @(negedge clk);
        check("mr_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        credits_m = int'(SC); reels_m = 12'd0; payout_m = 0;
        check("mr_credits", credits, credits_m);
        check("mr_busy0", busy, 0);
        check("mr_reels", reels, 0);
        check("mr_payout", payout, 0);
        @(negedge clk);
        check("mr_stay_idle", busy, 0);
        check("mr_no_done", done, 0);
    endtask

    initial begin
        logic [11:0] r;
        logic [3:0]  a, d;
        do_reset();

        spin(5, 12'h123, 0, 0, 0);
        spin(5, 12'h124, 0, 0, 0);
        spin(15, 12'h000, 0, 0, 0);
        spin(0, 12'h000, 0, 0, 0);

        do_reset();
        spin(3, 12'h555, 0, 0, 0);
        spin(2, 12'h553, 0, 0, 0);
        spin(4, 12'h9A9, 0, 1, 1);

        do_reset();
        spin(15, 12'hBBB, 0, 0, 0);
        repeat (6) spin(15, 12'hCC1, 0, 0, 0);
        spin(5, 12'h1DD, 0, 0, 0);
        spin(15, 12'hAAA, 0, 0, 0);
        spin(1, 12'h777, 0, 0, 0);

        mid_reset(9, 12'h456);

        for (int i = 0; i < 40; i++) begin
            if (credits_m < 3) do_reset();
            a = 4'($urandom);
            d = 4'($urandom);
            case ($urandom % 4)
                0:       r = {a, a, a};
                1:       r = {a, a, d};
                2:       r = {d, a, a};
                default: r = 12'($urandom);
            endcase
            spin(int'($urandom % 16), r, 1, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spin_sequencer.md
# spin_sequencer

Game controller for the slot machine. It accepts a spin request and checks the bet against the credit balance. It then debits the bet, stops the three reels one at a time from the free-running random count, evaluates the result and credits the payout. It sits between the mouse/bet-counter front end and the `driver7seg` reel displays, and replaces the direct middle-button latch of `reels`.

## Interface
Parameters:
- `REEL_DELAY`, 4: cycles between spin acceptance and each successive reel stop; must be ≥1.
- `START_CREDITS`, 8'd100: credit balance loaded on reset.

Ports:
- `clk` in 1: system clock (`CLOCK_50` at top level).
- `rst` in 1: synchronous, active-high reset.
- `spin_req` in 1: spin request level (middle button, already synchronised to `clk`); rising edge triggers a spin.
- `bet` in 4: bet amount from the bet counter, 0–15.
- `rand_cnt` in 12: free-running random count; three 4-bit reel fields.
- `reels` out 12: displayed reel values; [11:8] reel 0, [7:4] reel 1, [3:0] reel 2.
- `credits` out 8: current credit balance.
- `payout` out 8: payout of the last completed spin.
- `busy` out 1: high while a spin is in progress.
- `win` out 1: one-cycle pulse at completion when payout > 0.
- `done` out 1: one-cycle pulse at spin completion.
- `reject` out 1: one-cycle pulse when a request is refused.

## Operation
- **Edge detection.** `spin_req` is registered (`req_q`). The edge is `spin_req & ~req_q`.
- **States.** IDLE, STOP0, STOP1, STOP2, EVAL, CREDIT. `busy` = (state != IDLE), registered.
- **IDLE, accept.** On an edge with `bet != 0` and `credits >= bet`:
  - `credits <= credits - bet`
  - `bet_q <= bet`
  - `timer <= 0`
  - go to STOP0
- **IDLE, refuse.** On an edge with `bet == 0` or `bet > credits`: pulse `reject` for one cycle; state and credits unchanged.
- **STOPk (k = 0, 1, 2).**
  - `timer` increments every cycle.
  - When `timer == REEL_DELAY-1`: latch reel k's field of `rand_cnt` into `reels`, clear `timer`, advance to the next state (STOP2 advances to EVAL).
  - The other reel fields hold their values. A new spin leaves the previous reel values displayed until each reel is overwritten.
- **EVAL.** `payout` is registered as follows (r0, r1, r2 = reel fields):
  - r0 == r1 == r2: `bet_q*10` (max 150).
  - else if r0 == r1 or r1 == r2: `bet_q*2`.
  - else 0.
- **CREDIT.**
  - `credits <= min(credits + payout, 255)`, with the sum computed at 9 bits and saturated.
  - Pulse `done`; pulse `win` if `payout != 0`.
  - Return to IDLE.
- **Bet changes mid-spin.** The spin uses `bet_q`; later `bet` changes have no effect.
- **Edges while busy.** Ignored: not queued, no `reject`.
- **Held request.** Holding `spin_req` high gives exactly one spin.
- **Reset values.**
  - `credits = START_CREDITS`; `reels = 0`; `payout = 0`.
  - `busy`, `win`, `done`, `reject`, `req_q` all 0; state IDLE; `timer = 0`.
- **Reset mid-spin.** Aborts the spin immediately. No refund; credits reload to `START_CREDITS`.

## Timing
- **Cycle A.** The accepting clock edge: debit visible and `busy` = 1 after A.
- **Reel stops.** Reel 0 latches at A + `REEL_DELAY`, reel 1 at A + 2·`REEL_DELAY`, reel 2 at A + 3·`REEL_DELAY`.
- **Completion.**
  - `payout` is valid after A + 3·`REEL_DELAY` + 1.
  - Credit update, `done` and `win` occur after A + 3·`REEL_DELAY` + 2.
  - `busy` falls in that same cycle.
- **Next spin.** Earliest next acceptance is the cycle after `done`; a rising edge requires `spin_req` low for at least one sampled cycle.
- **Refusal.** `reject` is asserted the cycle after the refused edge is sampled.
- **Pipeline.** No combinational path from any input to any output.

## Configuration
- **`SPIN_SEQ_JACKPOT_EN`.**
  - Defined: EVAL gives `reels == 12'h777` a payout of 8'd255, so credits saturate to 255 at CREDIT.
  - Undefined: 777 is an ordinary triple paying `bet_q*10`.

## Test plan
Bench settings: `REEL_DELAY=4`, `START_CREDITS=20`.
- **Reset.** Assert `rst` 2 cycles → `credits` = 20, `reels` = 0, `payout` = 0, `busy` = 0, no pulses.
- **Losing spin.** `bet` = 5, `rand_cnt` = 12'h123 held, pulse `spin_req` →
  - `credits` = 15 one cycle after A.
  - Reels latch at A+4, A+8, A+12 (`reels` = 12'h123).
  - `done` at A+14, `payout` = 0, `win` = 0, `credits` = 15.
- **Triple and pair.**
  - `bet` = 3, `rand_cnt` = 12'h555 → `credits` 20→17→47, `win` = 1.
  - Then `bet` = 2, `rand_cnt` = 12'h553 → `payout` = 4, `credits` 47→45→49.
- **Refusals.**
  - `bet` = 0 → `reject` pulse, credits unchanged.
  - `bet` = 15 with `credits` = 10 → `reject` pulse, credits unchanged.
  - Edge while `busy` → no `reject`, no second spin.
- **Saturation and jackpot.**
  - `credits` = 250, `bet` = 15, `rand_cnt` = 12'hAAA → `credits` 235 → 255.
  - With `SPIN_SEQ_JACKPOT_EN`, `rand_cnt` = 12'h777, `bet` = 1 → `payout` = 255, `credits` = 255.
- **Mid-spin changes.**
  - Change `bet` to 9 after A → debit and payout still use the original bet.
  - Assert `rst` at A+6 → `credits` = 20, `busy` = 0, `reels` = 0 next cycle.
